calculator: RTL and testbench

CALCULATOR -- requirements
Module: calculator

---
 rtl/calc_pkg.sv | 30 +++
 rtl/calc_if.sv | 13 +
 rtl/stack_alu.sv | 57 +++++
 rtl/calculator.sv | 148 ++++++++++++++
 tb/tb_calculator.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared constants and types for the infix token calculator.
// Opcode values, default depths, token classes and the datapath command set.
package calc_pkg;

    localparam int DATA_W          = 16;
    localparam int DEF_STACK_DEPTH = 16;
    localparam int DEF_NEST_DEPTH  = 8;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_MUL   = 3'b001;
    localparam logic [2:0] OP_OPEN  = 3'b010;
    localparam logic [2:0] OP_CLOSE = 3'b011;
    localparam logic [2:0] OP_PUSH  = 3'b100;
    localparam logic [2:0] OP_EQUAL = 3'b101;

    typedef enum logic {
        CLS_OPERATOR = 1'b0,
        CLS_VALUE    = 1'b1
    } tok_class_t;

    typedef enum logic [2:0] {
        ALU_NOP,
        ALU_PUSH,
        ALU_MUL_TOP,
        ALU_ADD2,
        ALU_MUL2,
        ALU_ADD_MUL
    } alu_op_t;

endpackage

// File: rtl/calc_if.sv
// Token input and result output bundle of the calculator.
interface calc_if;
    import calc_pkg::*;

    logic [2:0]        opcode;
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] alu_result;
    logic              done;
    logic              error;

    modport master (output opcode, operand, input alu_result, done, error);
    modport slave  (input opcode, operand, output alu_result, done, error);
endinterface

// File: rtl/stack_alu.sv
// Value stack with push, replace-top and fold datapath.
// The caller guarantees enough entries / free space for every command issued.
module stack_alu
    import calc_pkg::*;
#(
    parameter int STACK_DEPTH = DEF_STACK_DEPTH,
    parameter int SPW         = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  alu_op_t           op,
    input  logic [DATA_W-1:0] operand,
    output logic [DATA_W-1:0] top,
    output logic [SPW-1:0]    stack_pointer
);

    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [DATA_W-1:0] stack [STACK_DEPTH];
    logic [IW-1:0]     i_push, i0, i1, i2;

    assign i_push = IW'(stack_pointer);
    assign i0     = IW'(stack_pointer - SPW'(1));
    assign i1     = IW'(stack_pointer - SPW'(2));
    assign i2     = IW'(stack_pointer - SPW'(3));

    assign top = (stack_pointer == '0) ? '0 : stack[i0];

    // Products keep only the low DATA_W bits, which is identical for signed data.
    always_ff @(posedge clk) begin
        if (rst) begin
            stack_pointer <= '0;
        end else begin
            case (op)
                ALU_PUSH: begin
                    stack[i_push] <= operand;
                    stack_pointer <= stack_pointer + SPW'(1);
                end
                ALU_MUL_TOP: stack[i0] <= stack[i0] * operand;
                ALU_ADD2: begin
                    stack[i1]     <= stack[i1] + stack[i0];
                    stack_pointer <= stack_pointer - SPW'(1);
                end
                ALU_MUL2: begin
                    stack[i1]     <= stack[i1] * stack[i0];
                    stack_pointer <= stack_pointer - SPW'(1);
                end
                ALU_ADD_MUL: begin
                    stack[i2]     <= stack[i2] * (stack[i1] + stack[i0]);
                    stack_pointer <= stack_pointer - SPW'(2);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/calculator.sv
// Infix calculator: token decoder, nesting level and per-level pending flags.
//   state        | meaning
//   CLS_OPERATOR | last accepted token was an operator/open; expecting a value
//   CLS_VALUE    | last accepted token was a value/close; expecting an operator
module calculator
    import calc_pkg::*;
#(
    parameter int STACK_DEPTH = DEF_STACK_DEPTH,
    parameter int NEST_DEPTH  = DEF_NEST_DEPTH
) (
    input  logic   clk,
    input  logic   rst,
    calc_if.slave  bus
);

    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int LW  = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

    tok_class_t            prev_class, nxt_class;
    logic [LW-1:0]         lvl, nxt_lvl, lvl_up, lvl_dn;
    logic [NEST_DEPTH-1:0] pending_mult_stack, pending_addition_stack;
    logic [NEST_DEPTH-1:0] nxt_pm, nxt_pa;
    logic                  done_q, error_q, nxt_done, nxt_error;
    logic                  accept, is_equal, add_f, mul_f;
    logic [1:0]            need;
    alu_op_t               alu_op;
    logic [SPW-1:0]        stack_pointer;
    logic [DATA_W-1:0]     top_val;

    stack_alu #(.STACK_DEPTH(STACK_DEPTH), .SPW(SPW)) u_alu (
        .clk           (clk),
        .rst           (rst),
        .op            (alu_op),
        .operand       (bus.operand),
        .top           (top_val),
        .stack_pointer (stack_pointer)
    );

    assign lvl_up = lvl + LW'(1);
    assign lvl_dn = lvl - LW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_class             <= CLS_OPERATOR;
            lvl                    <= '0;
            pending_mult_stack     <= '0;
            pending_addition_stack <= '0;
            done_q                 <= 1'b0;
            error_q                <= 1'b0;
        end else begin
            prev_class             <= nxt_class;
            lvl                    <= nxt_lvl;
            pending_mult_stack     <= nxt_pm;
            pending_addition_stack <= nxt_pa;
            done_q                 <= nxt_done;
            error_q                <= nxt_error;
        end
    end

    always_comb begin
        nxt_class = prev_class;
        nxt_lvl   = lvl;
        nxt_pm    = pending_mult_stack;
        nxt_pa    = pending_addition_stack;
        nxt_done  = done_q;
        nxt_error = error_q;
        alu_op    = ALU_NOP;
        accept    = 1'b0;
        is_equal  = 1'b0;
        add_f     = pending_addition_stack[lvl];
        mul_f     = pending_mult_stack[lvl_dn];
        need      = 2'd1;
        case (bus.opcode)
            OP_PUSH: if (prev_class == CLS_OPERATOR) begin
                if (pending_mult_stack[lvl]) begin
                    if (stack_pointer == '0) nxt_error = 1'b1;
                    else begin
                        alu_op      = ALU_MUL_TOP;
                        nxt_pm[lvl] = 1'b0;
                        accept      = 1'b1;
                    end
                end else if (stack_pointer == SPW'(STACK_DEPTH)) begin
                    nxt_error = 1'b1;
                end else begin
                    alu_op = ALU_PUSH;
                    accept = 1'b1;
                end
                if (accept) nxt_class = CLS_VALUE;
            end
            OP_ADD: if (prev_class == CLS_VALUE) begin
                if (add_f && stack_pointer < SPW'(2)) nxt_error = 1'b1;
                else begin
                    if (add_f) alu_op = ALU_ADD2;
                    nxt_pa[lvl] = 1'b1;
                    nxt_class   = CLS_OPERATOR;
                    accept      = 1'b1;
                end
            end
            OP_MUL: if (prev_class == CLS_VALUE) begin
                nxt_pm[lvl] = 1'b1;
                nxt_class   = CLS_OPERATOR;
                accept      = 1'b1;
            end
            OP_OPEN: begin
                if (lvl == LW'(NEST_DEPTH - 1)) nxt_error = 1'b1;
                else begin
                    nxt_lvl        = lvl_up;
                    nxt_pa[lvl_up] = 1'b0;
                    nxt_pm[lvl_up] = 1'b0;
                    nxt_class      = CLS_OPERATOR;
                    accept         = 1'b1;
                end
            end
            OP_CLOSE: begin
                // add fold at this level and mul fold at the outer level happen together
                need = 2'd1 + 2'(add_f) + 2'(mul_f);
                if (lvl == '0 || stack_pointer < SPW'(need)) nxt_error = 1'b1;
                else begin
                    if (add_f && mul_f) alu_op = ALU_ADD_MUL;
                    else if (add_f)     alu_op = ALU_ADD2;
                    else if (mul_f)     alu_op = ALU_MUL2;
                    nxt_pa[lvl]    = 1'b0;
                    nxt_pm[lvl]    = 1'b0;
                    nxt_pm[lvl_dn] = 1'b0;
                    nxt_lvl        = lvl_dn;
                    nxt_class      = CLS_VALUE;
                    accept         = 1'b1;
                end
            end
            OP_EQUAL: begin
                if (lvl != '0 || (add_f && stack_pointer < SPW'(2))) nxt_error = 1'b1;
                else begin
                    if (add_f) alu_op = ALU_ADD2;
                    nxt_pa[lvl] = 1'b0;
                    accept      = 1'b1;
                    is_equal    = 1'b1;
                end
            end
            default: ;
        endcase
        if (accept) nxt_done = is_equal;
    end

    assign bus.alu_result = top_val;
    assign bus.done       = done_q;
    assign bus.error      = error_q;

endmodule

// File: tb/tb_calculator.sv
// Directed and randomized checks of the calculator against a precedence-based evaluator.
module tb_calculator;
    import calc_pkg::*;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    calc_if bus ();
    calc_if bus_s ();

    assign bus_s.opcode  = bus.opcode;
    assign bus_s.operand = bus.operand;

    calculator u_main (.clk(clk), .rst(rst), .bus(bus));
    calculator #(.STACK_DEPTH(4), .NEST_DEPTH(8)) u_small (.clk(clk), .rst(rst), .bus(bus_s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  t_op  [64];
    logic [15:0] t_val [64];
    int          t_n;
    logic [15:0] vs [32];
    logic [2:0]  os [32];
    int          vsp;
    int          osp;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tok(input logic [2:0] op, input logic [15:0] val);
        @(negedge clk);
        bus.opcode  = op;
        bus.operand = val;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        bus.opcode  = OP_PUSH;
        bus.operand = 16'd99;
        @(posedge clk);
        #1;
        check("reset_result", bus.alu_result, 16'd0);
        check("reset_done", 16'(bus.done), 16'd0);
        check("reset_error", 16'(bus.error), 16'd0);
        @(negedge clk);
        rst        = 1'b0;
        bus.opcode = 3'b111;
        @(posedge clk);
        #1;
    endtask

    function automatic int prec(input logic [2:0] o);
        return (o == OP_MUL) ? 2 : 1;
    endfunction

    task automatic apply_top();
        logic [15:0] a, b, r;
        b = vs[vsp-1];
        a = vs[vsp-2];
        if (os[osp-1] == OP_MUL) r = a * b;
        else                     r = a + b;
        vsp        = vsp - 2;
        vs[vsp]    = r;
        vsp        = vsp + 1;
        osp        = osp - 1;
    endtask

    // Ordinary precedence evaluation: '*' binds tighter, both left-associative.
    task automatic model_eval(output logic [15:0] res);
        vsp = 0;
        osp = 0;
        for (int i = 0; i < t_n; i++) begin
            case (t_op[i])
                OP_PUSH: begin vs[vsp] = t_val[i]; vsp++; end
                OP_OPEN: begin os[osp] = OP_OPEN; osp++; end
                OP_ADD, OP_MUL: begin
                    while (osp > 0 && os[osp-1] != OP_OPEN && prec(os[osp-1]) >= prec(t_op[i]))
                        apply_top();
                    os[osp] = t_op[i];
                    osp++;
                end
                OP_CLOSE: begin
                    while (os[osp-1] != OP_OPEN) apply_top();
                    osp--;
                end
                default: while (osp > 0) apply_top();
            endcase
        end
        res = vs[0];
    endtask

    task automatic gen_expr();
        int  depth;
        int  terms;
        bit  need_val;
        t_n      = 0;
        depth    = 0;
        terms    = 0;
        need_val = 1'b1;
        forever begin
            if (need_val) begin
                if (depth < 3 && $urandom_range(0, 3) == 0) begin
                    t_op[t_n] = OP_OPEN; t_val[t_n] = 16'd0; t_n++; depth++;
                end else begin
                    t_op[t_n]  = OP_PUSH;
                    t_val[t_n] = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 65535))
                                                             : 16'($urandom_range(0, 20));
                    t_n++; terms++; need_val = 1'b0;
                end
            end else if (depth > 0 && ($urandom_range(0, 5) < 2 || terms >= 6)) begin
                t_op[t_n] = OP_CLOSE; t_val[t_n] = 16'd0; t_n++; depth--;
            end else if (terms >= 6) begin
                break;
            end else begin
                t_op[t_n]  = ($urandom_range(0, 1) == 0) ? OP_ADD : OP_MUL;
                t_val[t_n] = 16'd0;
                t_n++; need_val = 1'b1;
            end
        end
        t_op[t_n] = OP_EQUAL; t_val[t_n] = 16'd0; t_n++;
    endtask

    initial begin
        logic [15:0] exp_v;
        compared    = 0;
        mismatched  = 0;
        rst         = 1'b1;
        bus.opcode  = OP_PUSH;
        bus.operand = 16'd55;
        repeat (2) @(posedge clk);
        #1;
        check("init_result", bus.alu_result, 16'd0);
        check("init_done", 16'(bus.done), 16'd0);
        check("init_error", 16'(bus.error), 16'd0);
        do_reset();

        // operator straight after reset is ignored
        tok(OP_ADD, 16'd0);
        check("add_after_reset_result", bus.alu_result, 16'd0);
        check("add_after_reset_error", 16'(bus.error), 16'd0);
        check("add_after_reset_sp", 16'(u_main.u_alu.stack_pointer), 16'd0);

        // ( 2 * 3 + ( 10 + 4 + 3 ) * -20 + ( 6 + 5 ) ) with held pushes
        do_reset();
        tok(OP_OPEN, 0);   tok(OP_PUSH, 16'd2);  tok(OP_MUL, 0);
        tok(OP_PUSH, 16'd3); tok(OP_PUSH, 16'd3);
        check("held_push_mul", bus.alu_result, 16'd6);
        tok(OP_ADD, 0);    tok(OP_OPEN, 0);      tok(OP_PUSH, 16'd10);
        tok(OP_ADD, 0);    tok(OP_PUSH, 16'd4);  tok(OP_ADD, 0);
        tok(OP_PUSH, 16'd3); tok(OP_CLOSE, 0);
        check("inner_paren", bus.alu_result, 16'd17);
        tok(OP_MUL, 0);    tok(OP_PUSH, 16'hFFEC); tok(OP_PUSH, 16'hFFEC);
        check("neg_product", bus.alu_result, 16'hFEAC);
        tok(OP_ADD, 0);    tok(OP_OPEN, 0);      tok(OP_PUSH, 16'd6);
        tok(OP_ADD, 0);    tok(OP_PUSH, 16'd5);  tok(OP_CLOSE, 0);
        tok(OP_CLOSE, 0);
        check("long_expr_result", bus.alu_result, 16'hFEBD);
        check("long_expr_error", 16'(bus.error), 16'd0);

        // 2 * ( 3 + 4 ) =
        do_reset();
        tok(OP_PUSH, 16'd2); tok(OP_MUL, 0); tok(OP_OPEN, 0); tok(OP_PUSH, 16'd3);
        tok(OP_ADD, 0); tok(OP_PUSH, 16'd4); tok(OP_CLOSE, 0);
        check("close_mul_fold", bus.alu_result, 16'd14);
        check("done_before_equal", 16'(bus.done), 16'd0);
        tok(OP_EQUAL, 0);
        check("paren_mul_result", bus.alu_result, 16'd14);
        check("paren_mul_done", 16'(bus.done), 16'd1);

        // 7FFF + 1 = wraps; a following accepted ADD drops done
        do_reset();
        tok(OP_PUSH, 16'h7FFF); tok(OP_ADD, 0); tok(OP_PUSH, 16'd1); tok(OP_EQUAL, 0);
        check("wrap_result", bus.alu_result, 16'h8000);
        check("wrap_error", 16'(bus.error), 16'd0);
        check("wrap_done", 16'(bus.done), 16'd1);
        tok(OP_ADD, 0);
        check("done_cleared", 16'(bus.done), 16'd0);

        // reset mid-expression
        do_reset();
        tok(OP_OPEN, 0); tok(OP_PUSH, 16'd5); tok(OP_ADD, 0);
        do_reset();
        tok(OP_PUSH, 16'd7); tok(OP_EQUAL, 0);
        check("after_midreset_result", bus.alu_result, 16'd7);
        check("after_midreset_done", 16'(bus.done), 16'd1);
        check("after_midreset_error", 16'(bus.error), 16'd0);

        // stack overflow on a 4-deep instance: 1 + 2 * ( 3 + 4 * ( 5
        do_reset();
        tok(OP_PUSH, 16'd1); tok(OP_ADD, 0); tok(OP_PUSH, 16'd2); tok(OP_MUL, 0);
        tok(OP_OPEN, 0); tok(OP_PUSH, 16'd3); tok(OP_ADD, 0); tok(OP_PUSH, 16'd4);
        tok(OP_MUL, 0); tok(OP_OPEN, 0);
        check("small_pre_full_error", 16'(bus_s.error), 16'd0);
        tok(OP_PUSH, 16'd5);
        check("small_overflow_error", 16'(bus_s.error), 16'd1);
        check("small_overflow_sp", 16'(u_small.u_alu.stack_pointer), 16'd4);
        check("small_overflow_top", bus_s.alu_result, 16'd4);
        check("main_no_overflow", bus.alu_result, 16'd5);
        check("main_no_overflow_error", 16'(bus.error), 16'd0);

        // fill the default stack to 16 across all 8 levels, then one OPEN too many
        do_reset();
        for (int l = 0; l < 7; l++) begin
            tok(OP_PUSH, 16'(l + 1)); tok(OP_ADD, 0); tok(OP_PUSH, 16'(l + 100));
            tok(OP_MUL, 0); tok(OP_OPEN, 0);
        end
        tok(OP_PUSH, 16'd8); tok(OP_ADD, 0); tok(OP_PUSH, 16'd200);
        check("full_sp", 16'(u_main.u_alu.stack_pointer), 16'd16);
        check("full_top", bus.alu_result, 16'd200);
        check("full_error", 16'(bus.error), 16'd0);
        tok(OP_OPEN, 0);
        check("nest_overflow_error", 16'(bus.error), 16'd1);

        // CLOSE at level 0 and EQUAL inside a parenthesis
        do_reset();
        tok(OP_PUSH, 16'd3); tok(OP_CLOSE, 0);
        check("close_lvl0_error", 16'(bus.error), 16'd1);
        check("close_lvl0_top", bus.alu_result, 16'd3);
        do_reset();
        tok(OP_OPEN, 0); tok(OP_PUSH, 16'd1); tok(OP_EQUAL, 0);
        check("equal_nested_error", 16'(bus.error), 16'd1);
        check("equal_nested_done", 16'(bus.done), 16'd0);

        // random well-formed expressions with held tokens and ignored opcodes
        for (int e = 0; e < 30; e++) begin
            do_reset();
            gen_expr();
            model_eval(exp_v);
            for (int i = 0; i < t_n; i++) begin
                if ($urandom_range(0, 4) == 0)
                    tok(3'b110 | 3'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)));
                tok(t_op[i], t_val[i]);
                if ((t_op[i] == OP_PUSH || t_op[i] == OP_ADD || t_op[i] == OP_MUL)
                    && $urandom_range(0, 2) == 0)
                    tok(t_op[i], t_val[i]);
            end
            check($sformatf("rand%0d_result", e), bus.alu_result, exp_v);
            check($sformatf("rand%0d_done", e), 16'(bus.done), 16'd1);
            check($sformatf("rand%0d_error", e), 16'(bus.error), 16'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
